vga_framebuffer_reader: RTL and testbench

Scan-out engine for the ADV7123 VGA DAC path. Generates 640x480@60 VGA timing from the single pixel clock and reads the 320x240 24-bit frame buffer with 2x horizontal and vertical pixel replication. It drives the frame buffer's read address and forwards the returned pixel, with matched sync and blank, to the DAC pins. It is the read-side counterpart to the frame buffer's write port.

---
 rtl/vga_framebuffer_reader_if.sv | 51 +++++
 rtl/vga_framebuffer_reader.sv | 181 ++++++++++++++++++
 tb/tb_vga_framebuffer_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_framebuffer_reader_if.sv
// ----------------------------------------------------------------------------
// vga_framebuffer_reader_if
// Groups the scan-out engine's frame buffer read port and its DAC-side
// outputs into one bundle.
//   piul1Enable        scan-out enable (sampled by the reader at frame boundary)
//   poul17ReadAddress  frame buffer read address
//   piul24ReadData     frame buffer read data {R,G,B}, one clock after address
//   poul8Red/Green/Blue DAC colour data
//   poul1HSyncN/VSyncN active-low syncs
//   poul1BlankN        ADV7123 BLANK_n, high only on visible pixels
//   poul1FrameStart    one-clock pulse with pixel (0,0) on the colour outputs
// Modport master is the reader; slave is the frame buffer / DAC side.
// ----------------------------------------------------------------------------
interface vga_framebuffer_reader_if;
    logic        piul1Enable;
    logic [16:0] poul17ReadAddress;
    logic [23:0] piul24ReadData;
    logic [7:0]  poul8Red;
    logic [7:0]  poul8Green;
    logic [7:0]  poul8Blue;
    logic        poul1HSyncN;
    logic        poul1VSyncN;
    logic        poul1BlankN;
    logic        poul1FrameStart;

    modport master (
        input  piul1Enable,
        input  piul24ReadData,
        output poul17ReadAddress,
        output poul8Red,
        output poul8Green,
        output poul8Blue,
        output poul1HSyncN,
        output poul1VSyncN,
        output poul1BlankN,
        output poul1FrameStart
    );

    modport slave (
        output piul1Enable,
        output piul24ReadData,
        input  poul17ReadAddress,
        input  poul8Red,
        input  poul8Green,
        input  poul8Blue,
        input  poul1HSyncN,
        input  poul1VSyncN,
        input  poul1BlankN,
        input  poul1FrameStart
    );
endinterface

// File: rtl/vga_framebuffer_reader.sv
// ----------------------------------------------------------------------------
// vga_framebuffer_reader
// VGA scan-out engine: generates display timing from the pixel clock, reads a
// half-resolution frame buffer with 2x2 pixel replication and forwards the
// returned pixel with matched sync/blank/frame-start to the DAC.
// Ports:
//   piul1Clock   pixel clock, rising edge
//   piul1ResetN  asynchronous active-low reset
//   bus          vga_framebuffer_reader_if.master (read port + DAC outputs)
// Every DAC-side output is three clocks behind the timing counters; the read
// address is one clock behind them.
// ----------------------------------------------------------------------------
module vga_framebuffer_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                     piul1Clock,
    input  logic                     piul1ResetN,
    vga_framebuffer_reader_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 24;

    localparam logic [HC_W-1:0]   HC_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]   HC_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]   HS_FIRST  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]   HS_LAST   = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0]   VC_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]   VC_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]   VS_FIRST  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]   VS_LAST   = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [HC_W-1:0]     r_hc;
    logic [VC_W-1:0]     r_vc;
    logic [ADDR_W-1:0]   r_line_base;

    logic                w_line_end;
    logic                w_frame_end;
    logic                w_scan;
    logic                w_vld;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_hs_n;
    logic                w_vs_n;
    logic                w_fs;

    logic [ADDR_W-1:0]   r_addr_p1;
    logic                r_vld_p1, r_hs_n_p1, r_vs_n_p1, r_fs_p1;
    logic                r_vld_p2, r_hs_n_p2, r_vs_n_p2, r_fs_p2;
    logic [DATA_W-1:0]   r_rgb_p3;
    logic                r_vld_p3, r_hs_n_p3, r_vs_n_p3, r_fs_p3;

    // Colour is forced to black whenever the pixel is not visible.
    function automatic logic [DATA_W-1:0] blank_pixel(input logic vld,
                                                      input logic [DATA_W-1:0] px);
        return vld ? px : '0;
    endfunction

    assign w_line_end  = (r_hc == HC_LAST);
    assign w_frame_end = w_line_end && (r_vc == VC_LAST);
    assign w_scan      = (r_state == SCAN);

    always_ff @(posedge piul1Clock or negedge piul1ResetN) begin
        if (!piul1ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Enable is only looked at in IDLE or on the last clock of a frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (bus.piul1Enable) w_state_next = SCAN;
            SCAN: if (w_frame_end && !bus.piul1Enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Timing counters. The line base steps by one buffer row after every odd
    // visible line, which gives (vc>>1)*row_width without a multiplier.
    always_ff @(posedge piul1Clock or negedge piul1ResetN) begin
        if (!piul1ResetN) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_line_base <= '0;
        end else if (!w_scan || w_frame_end) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_line_base <= '0;
        end else if (w_line_end) begin
            r_hc <= '0;
            r_vc <= r_vc + 1'b1;
            if (r_vc[0] && (r_vc < VC_ACT)) begin
                r_line_base <= r_line_base + LINE_STEP;
            end
        end else begin
            r_hc <= r_hc + 1'b1;
        end
    end

    assign w_vld  = w_scan && (r_hc < HC_ACT) && (r_vc < VC_ACT);
    assign w_addr = w_vld ? (r_line_base + {{(ADDR_W - HC_W + 1){1'b0}}, r_hc[HC_W-1:1]})
                          : '0;
    assign w_hs_n = !(w_scan && (r_hc >= HS_FIRST) && (r_hc <= HS_LAST));
    assign w_vs_n = !(w_scan && (r_vc >= VS_FIRST) && (r_vc <= VS_LAST));
    assign w_fs   = w_scan && (r_hc == '0) && (r_vc == '0);

    // Stage p1: read address issued, controls registered alongside.
    always_ff @(posedge piul1Clock or negedge piul1ResetN) begin
        if (!piul1ResetN) begin
            r_addr_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_hs_n_p1 <= 1'b1;
            r_vs_n_p1 <= 1'b1;
            r_fs_p1   <= 1'b0;
        end else begin
            r_addr_p1 <= w_addr;
            r_vld_p1  <= w_vld;
            r_hs_n_p1 <= w_hs_n;
            r_vs_n_p1 <= w_vs_n;
            r_fs_p1   <= w_fs;
        end
    end

    // Stage p2: frame buffer returns data; controls wait one clock to match.
    always_ff @(posedge piul1Clock or negedge piul1ResetN) begin
        if (!piul1ResetN) begin
            r_vld_p2  <= 1'b0;
            r_hs_n_p2 <= 1'b1;
            r_vs_n_p2 <= 1'b1;
            r_fs_p2   <= 1'b0;
        end else begin
            r_vld_p2  <= r_vld_p1;
            r_hs_n_p2 <= r_hs_n_p1;
            r_vs_n_p2 <= r_vs_n_p1;
            r_fs_p2   <= r_fs_p1;
        end
    end

    // Stage p3: DAC output registers, colour and controls aligned.
    always_ff @(posedge piul1Clock or negedge piul1ResetN) begin
        if (!piul1ResetN) begin
            r_rgb_p3  <= '0;
            r_vld_p3  <= 1'b0;
            r_hs_n_p3 <= 1'b1;
            r_vs_n_p3 <= 1'b1;
            r_fs_p3   <= 1'b0;
        end else begin
            r_rgb_p3  <= blank_pixel(r_vld_p2, bus.piul24ReadData);
            r_vld_p3  <= r_vld_p2;
            r_hs_n_p3 <= r_hs_n_p2;
            r_vs_n_p3 <= r_vs_n_p2;
            r_fs_p3   <= r_fs_p2;
        end
    end

    assign bus.poul17ReadAddress = r_addr_p1;
    assign bus.poul8Red          = r_rgb_p3[23:16];
    assign bus.poul8Green        = r_rgb_p3[15:8];
    assign bus.poul8Blue         = r_rgb_p3[7:0];
    assign bus.poul1HSyncN       = r_hs_n_p3;
    assign bus.poul1VSyncN       = r_vs_n_p3;
    assign bus.poul1BlankN       = r_vld_p3;
    assign bus.poul1FrameStart   = r_fs_p3;
endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// ----------------------------------------------------------------------------
// tb_vga_framebuffer_reader
// Two instances: a reduced-geometry reader checked cycle by cycle against a
// frame-position reference model through a scoreboard, and a full 640x480
// reader checked at specific pixels of its first lines.
// ----------------------------------------------------------------------------
module tb_vga_framebuffer_reader;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [44:0] IDLE_PAT = {17'd0, 24'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [16:0] addr;
        logic [23:0] rgb;
        logic        blank_n;
        logic        hs_n;
        logic        vs_n;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_full_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ram_mode = 0;
    logic [23:0] mem [256];
    exp_t q[$];
    exp_t mon_e, mon_ea;
    bit   m_scan = 0;
    int   m_pos  = 0;
    bit   full_done = 0;
    int   hs_low = 0;

    vga_framebuffer_reader_if bus_s();
    vga_framebuffer_reader_if bus_f();

    vga_framebuffer_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) u_dut (
        .piul1Clock (clk),
        .piul1ResetN(rst_n),
        .bus        (bus_s)
    );

    vga_framebuffer_reader u_full (
        .piul1Clock (clk),
        .piul1ResetN(rst_full_n),
        .bus        (bus_f)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ram_val(input logic [16:0] a);
        case (ram_mode)
            0:       return {7'd0, a};
            1:       return 24'hFFFFFF;
            default: return mem[a[7:0]];
        endcase
    endfunction

    // Synchronous frame buffer: data one clock after the address.
    always @(posedge clk) bus_s.piul24ReadData <= ram_val(bus_s.poul17ReadAddress);
    always @(posedge clk) bus_f.piul24ReadData <= {7'd0, bus_f.poul17ReadAddress};

    function automatic logic [44:0] pack_out(input logic [16:0] a, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b,
                                             input logic bl, input logic hs, input logic vs,
                                             input logic fs);
        return {a, r, g, b, bl, hs, vs, fs};
    endfunction

    function automatic logic [44:0] out_s();
        return pack_out(bus_s.poul17ReadAddress, bus_s.poul8Red, bus_s.poul8Green,
                        bus_s.poul8Blue, bus_s.poul1BlankN, bus_s.poul1HSyncN,
                        bus_s.poul1VSyncN, bus_s.poul1FrameStart);
    endfunction

    function automatic logic [44:0] out_f();
        return pack_out(bus_f.poul17ReadAddress, bus_f.poul8Red, bus_f.poul8Green,
                        bus_f.poul8Blue, bus_f.poul1BlankN, bus_f.poul1HSyncN,
                        bus_f.poul1VSyncN, bus_f.poul1FrameStart);
    endfunction

    // Reference: what the screen should show for linear frame position pos.
    function automatic exp_t expect_out(input bit scan, input int pos);
        exp_t e;
        int h, v;
        bit act;
        h   = pos % HT;
        v   = pos / HT;
        act = scan && (h < HA) && (v < VA);
        e.addr    = act ? 17'((v / 2) * (HA / 2) + h / 2) : 17'd0;
        e.rgb     = act ? ram_val(e.addr) : 24'd0;
        e.blank_n = act;
        e.hs_n    = !(scan && (h >= HA + HFP) && (h < HA + HFP + HS));
        e.vs_n    = !(scan && (v >= VA + VFP) && (v < VA + VFP + VS));
        e.fs      = scan && (pos == 0);
        return e;
    endfunction

    // Model: advances frame position on every edge and queues the expectation.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            q.delete();
            repeat (3) q.push_back(expect_out(1'b0, 0));
            m_scan = 1'b0;
            m_pos  = 0;
        end else begin
            if (!m_scan) begin
                if (bus_s.piul1Enable) begin
                    m_scan = 1'b1;
                    m_pos  = 0;
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos = 0;
                if (!bus_s.piul1Enable) m_scan = 1'b0;
            end else begin
                m_pos++;
            end
            q.push_back(expect_out(m_scan, m_pos));
        end
    end

    // Monitor: address is one clock behind the counters, DAC outputs three.
    always @(negedge clk) begin
        if (rst_n && q.size() >= 4) begin
            mon_ea = q[q.size() - 2];
            mon_e  = q.pop_front();
            check("addr", 64'(bus_s.poul17ReadAddress), 64'(mon_ea.addr));
            check("dac", 64'({bus_s.poul8Red, bus_s.poul8Green, bus_s.poul8Blue,
                              bus_s.poul1BlankN, bus_s.poul1HSyncN, bus_s.poul1VSyncN,
                              bus_s.poul1FrameStart}),
                  64'({mon_e.rgb, mon_e.blank_n, mon_e.hs_n, mon_e.vs_n, mon_e.fs}));
        end
    end

    task automatic wait_pos(input int target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(posedge clk);
            #2;
            if (m_scan && m_pos == target) found = 1'b1;
        end
        check("wait_pos", 64'(found), 64'd1);
    endtask

    task automatic do_reset(input int mode);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'(out_s()), 64'(IDLE_PAT));
        repeat (2) @(posedge clk);
        ram_mode = mode;
        if (mode == 2) begin
            for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Full-size instance: spot checks on the first three lines.
    initial begin
        rst_full_n = 1'b0;
        bus_f.piul1Enable = 1'b1;
        @(negedge clk);
        check("full_reset", 64'(out_f()), 64'(IDLE_PAT));
        repeat (3) @(posedge clk);
        #2;
        rst_full_n = 1'b1;
        for (int m = 0; m < 1700; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (m >= 3 && m < 803 && !bus_f.poul1HSyncN) hs_low++;
            case (m)
                3:    check("full_fs_first", 64'({bus_f.poul1FrameStart, bus_f.poul1BlankN,
                                                 bus_f.poul8Red, bus_f.poul8Green, bus_f.poul8Blue}),
                            64'({1'b1, 1'b1, 24'd0}));
                4:    check("full_fs_pulse", 64'({bus_f.poul1FrameStart, bus_f.poul8Blue}), 64'd0);
                5:    check("full_pix2", 64'({bus_f.poul8Red, bus_f.poul8Green, bus_f.poul8Blue}), 64'd1);
                640:  check("full_addr_h639", 64'(bus_f.poul17ReadAddress), 64'd319);
                641:  check("full_addr_hblank", 64'(bus_f.poul17ReadAddress), 64'd0);
                642:  check("full_pix639", 64'({bus_f.poul1BlankN, bus_f.poul8Red, bus_f.poul8Green,
                                               bus_f.poul8Blue}), 64'({1'b1, 24'd319}));
                643:  check("full_pix640", 64'({bus_f.poul1BlankN, bus_f.poul8Red, bus_f.poul8Green,
                                               bus_f.poul8Blue}), 64'd0);
                658:  check("full_hs_before", 64'(bus_f.poul1HSyncN), 64'd1);
                659:  check("full_hs_start", 64'(bus_f.poul1HSyncN), 64'd0);
                754:  check("full_hs_last", 64'(bus_f.poul1HSyncN), 64'd0);
                755:  check("full_hs_after", 64'(bus_f.poul1HSyncN), 64'd1);
                801:  check("full_addr_v1", 64'(bus_f.poul17ReadAddress), 64'd0);
                803:  check("full_addr_v1h2", 64'(bus_f.poul17ReadAddress), 64'd1);
                1000: check("full_vs_high", 64'(bus_f.poul1VSyncN), 64'd1);
                1601: check("full_addr_v2", 64'(bus_f.poul17ReadAddress), 64'd320);
                1603: check("full_addr_v2h2", 64'(bus_f.poul17ReadAddress), 64'd321);
                default: ;
            endcase
        end
        check("full_hs_width", 64'(hs_low), 64'd96);
        full_done = 1'b1;
    end

    // Stimulus for the reduced-geometry instance.
    initial begin
        rst_n = 1'b0;
        bus_s.piul1Enable = 1'b0;
        ram_mode = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(out_s()), 64'(IDLE_PAT));

        // Enable high from reset, identity frame buffer.
        bus_s.piul1Enable = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2 * FRAME + 5) @(posedge clk);

        // Drop enable mid-frame: frame completes, then idles.
        wait_pos((VA / 2) * HT + HA / 2 + 3);
        bus_s.piul1Enable = 1'b0;
        for (int i = 0; i < 2 * FRAME && m_scan; i++) @(posedge clk);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("idle_outputs", 64'(out_s()), 64'(IDLE_PAT));
        @(posedge clk);
        #2;
        bus_s.piul1Enable = 1'b1;
        repeat (FRAME + 20) @(posedge clk);

        // Constant white frame buffer: blanking must force black.
        repeat ($urandom_range(1, HT)) @(posedge clk);
        do_reset(1);
        repeat (FRAME + 20) @(posedge clk);

        // Random frame buffer contents with random enable activity.
        repeat ($urandom_range(1, HT)) @(posedge clk);
        do_reset(2);
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 400)) @(posedge clk);
            #2;
            bus_s.piul1Enable = 1'($urandom_range(0, 1));
            if (k == 10) begin
                bus_s.piul1Enable = 1'b1;
                repeat ($urandom_range(FRAME / 2, FRAME)) @(posedge clk);
                do_reset(2);
            end
        end
        bus_s.piul1Enable = 1'b1;
        repeat (FRAME + 20) @(posedge clk);

        for (int i = 0; i < 5000 && !full_done; i++) @(posedge clk);
        check("full_done", 64'(full_done), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
